program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Upstream stage for the 8-bit CPU core. It receives a length-prefixed program over a byte valid/ready stream and assembles the 64-bit instruction image. It holds the CPU in reset while loading, releases it to run, and watches its halt flag. When the CPU halts or a watchdog expires, it captures o1/o2 into result registers and presents them on a valid/ack handshake.

Parameters:
MEM_BYTES, 8, instruction image size in bytes; i_mem width = MEM_BYTES*8.
MAX_CYCLES, 255, watchdog limit on RUN cycles; must fit in CYCLE_W.
CYCLE_W, 16, width of the run-cycle counter.
RST_CYCLES, 1, cycles cpu_rst is held high in RESET state before RUN.

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_data  input  8  program stream byte (UInt8)
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
i_mem  output  MEM_BYTES*8  instruction image to CPU; byte k at [k*8+:8]
cpu_rst  output  1  reset to CPU, active high
cpu_halt  input  1  CPU halt flag
cpu_o1  input  8  CPU output register o1
cpu_o2  input  8  CPU output register o2
res_o1  output  8  captured o1
res_o2  output  8  captured o2
res_valid  output  1  result available
res_ack  input  1  consumer takes result
timeout  output  1  result ended by watchdog, qualified by res_valid
len_err  output  1  one-cycle pulse: rejected length byte
cycles  output  CYCLE_W  RUN cycles of the last or current run
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low. On rst_n=0: state=IDLE, i_mem=0, cpu_rst=1, in_ready=0 (goes to 1 on the first clock in IDLE), res_o1=res_o2=0, res_valid=0, timeout=0, len_err=0, cycles=0, byte counter=0. Reset mid-operation aborts immediately; there is no partial state.
- A byte transfers when in_valid && in_ready on a rising edge. in_ready=1 only in IDLE and LOAD.
- cpu_rst=1 in every state except RUN.
- IDLE: the first accepted byte is the length L.
  - 1<=L<=MEM_BYTES: clear i_mem to 0, set remaining=L, go to LOAD.
  - L=0: clear i_mem, go to RESET. The all-zero image is an immediate halt.
  - L>MEM_BYTES: pulse len_err for 1 cycle, stay in IDLE, leave i_mem unchanged.
- LOAD: the k-th accepted byte (k=0..L-1) writes i_mem[k*8+:8]. Unwritten bytes stay 0, which is the halt opcode. After byte L-1 is accepted, go to RESET. Gaps in in_valid are allowed and cost no data.
- RESET: hold cpu_rst=1 for RST_CYCLES cycles, clear cycles to 0, then go to RUN.
- RUN: cpu_rst=0; cycles increments every cycle, saturating at MAX_CYCLES.
  - cpu_halt=1 sampled: capture cpu_o1/cpu_o2 into res_o1/res_o2, timeout=0, go to DONE.
  - Otherwise, when cycles==MAX_CYCLES: capture cpu_o1/cpu_o2, timeout=1, go to DONE.
  - If halt and watchdog expire on the same cycle, halt wins and timeout=0.
- DONE: res_valid=1. Results, timeout and cycles stay stable until res_ack is sampled high. Then res_valid=0 next cycle and state goes to IDLE. res_o*/cycles are retained until the next capture or RESET.
- The image is readable by the CPU from RESET onward and is never modified during RUN or DONE.
- Latencies:
  - Last program byte to first RUN cycle: 1+RST_CYCLES clocks.
  - cpu_halt sampled to res_valid=1: 1 clock.
- Width rules: byte counter is clog2(MEM_BYTES+1) bits. Comparison L>MEM_BYTES is done on the full 8-bit value.

Decomposition:
- Shared package (types.sv): UInt8 typedef and an enum LoaderState {IDLE, LOAD, RESET, RUN, DONE}. Add the HALT opcode constant 0 alongside the existing opcode constants.
- One natural sub-module: loader_watchdog, the saturating CYCLE_W run counter with a clear input and an expired flag. Everything else stays in the top level.

Test Plan:
- Stream 4,2,5,7,0 with in_valid held high → i_mem=64'h0000_0000_0007_0502. cpu_rst falls 1+RST_CYCLES clocks after the last byte. Then res_valid=1, res_o1=5, res_o2=0, timeout=0, cycles=3.
- Stream 0 → i_mem=0, CPU halts on the first RUN cycle, res_valid=1, res_o1=res_o2=0, cycles=1.
- Stream 9 → len_err pulses 1 cycle, state stays IDLE, i_mem unchanged. A following valid load (2,1,0) proceeds normally.
- Stream 2,1,0 (jump-to-self loop) → no halt, timeout=1 and res_valid=1 when cycles=255, res_o1=0.
- Same program as the first case with in_valid toggling every other cycle, and res_ack held low for 10 cycles → identical i_mem and results. Results stay stable while res_valid=1, and state returns to IDLE one cycle after res_ack.
- Drop rst_n asynchronously mid-LOAD (after 2 of 4 bytes) → all outputs immediately at reset values, cpu_rst=1. A fresh full load then succeeds.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
//   uint8_t        : byte type used on the program stream and CPU outputs
//   loader_state_t : loader FSM states
//   OP_HALT        : CPU halt opcode; an all-zero image halts immediately
package program_loader_pkg;

  typedef logic [7:0] uint8_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } loader_state_t;

  localparam uint8_t OP_HALT = 8'h00;

endpackage

// File: rtl/program_loader_watchdog.sv
// Saturating run-cycle counter for the program loader.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count one cycle
//   count      : current cycle count, saturates at MAX_CYCLES
//   expired    : count has reached MAX_CYCLES
module loader_watchdog #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [CYCLE_W-1:0] count,
  output logic               expired
);

  assign expired = (count == CYCLE_W'(MAX_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CYCLE_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed program over a byte stream,
// builds the CPU instruction image, runs the CPU and captures its result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/valid/ready : program byte stream (first byte is the length)
//   i_mem               : instruction image, byte k at [k*8+:8]
//   cpu_rst             : CPU reset, high in every state except RUN
//   cpu_halt/o1/o2      : CPU halt flag and output registers
//   res_o1/o2, timeout  : captured result, timeout means watchdog ended run
//   res_valid/res_ack   : result handshake
//   len_err             : one-cycle pulse on a rejected length byte
//   cycles              : RUN cycles of the last or current run
//   busy                : loader not idle
//   dbg_state           : current FSM state
//
// Handshakes: a stream byte moves on a rising edge where in_valid && in_ready;
// in_ready depends only on loader state, never on in_valid. A result is held
// stable while res_valid is high and is consumed on the edge where res_ack is
// high; res_valid drops on the following cycle.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEM_BYTES  = 8,
  parameter int MAX_CYCLES = 255,
  parameter int CYCLE_W    = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [MEM_BYTES*8-1:0] i_mem,
  output logic                   cpu_rst,
  input  logic                   cpu_halt,
  input  logic [7:0]             cpu_o1,
  input  logic [7:0]             cpu_o2,
  output logic [7:0]             res_o1,
  output logic [7:0]             res_o2,
  output logic                   res_valid,
  input  logic                   res_ack,
  output logic                   timeout,
  output logic                   len_err,
  output logic [CYCLE_W-1:0]     cycles,
  output logic                   busy,
  output loader_state_t          dbg_state
);

  localparam int     CNT_W       = $clog2(MEM_BYTES + 1);
  localparam int     RC_W        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam uint8_t MEM_BYTES_B = 8'(MEM_BYTES);

  loader_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [RC_W-1:0]  rst_cnt;
  logic             accept;
  logic             len_zero;
  logic             len_bad;
  logic             last_byte;
  logic             rst_done;
  logic             wd_expired;

  assign accept    = in_valid && in_ready;
  assign len_zero  = (in_data == 8'd0);
  // Compared on the full byte so lengths above 2**CNT_W are still rejected.
  assign len_bad   = (in_data > MEM_BYTES_B);
  assign last_byte = ((cnt + CNT_W'(1)) == len_q);
  assign rst_done  = (rst_cnt == RC_W'(RST_CYCLES - 1));

  assign cpu_rst   = (state != ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_DONE);
  assign dbg_state = state;

  loader_watchdog #(
    .CYCLE_W   (CYCLE_W),
    .MAX_CYCLES(MAX_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == ST_RESET),
    .en     (state == ST_RUN),
    .count  (cycles),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (len_zero)     state_nxt = ST_RESET;
          else if (!len_bad) state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  if (accept && last_byte)     state_nxt = ST_RESET;
      ST_RESET: if (rst_done)                state_nxt = ST_RUN;
      ST_RUN:   if (cpu_halt || wd_expired)  state_nxt = ST_DONE;
      ST_DONE:  if (res_ack)                 state_nxt = ST_IDLE;
      default:                               state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      len_err  <= 1'b0;
      i_mem    <= '0;
      cnt      <= '0;
      len_q    <= '0;
      rst_cnt  <= '0;
      res_o1   <= '0;
      res_o2   <= '0;
      timeout  <= 1'b0;
    end else begin
      // Registered so the stream sees a stable ready for the whole cycle.
      in_ready <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
      len_err  <= (state == ST_IDLE) && accept && len_bad;
      case (state)
        ST_IDLE: begin
          if (accept && !len_bad) begin
            // Unwritten bytes must read as halt.
            i_mem <= {MEM_BYTES{OP_HALT}};
            len_q <= in_data[CNT_W-1:0];
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            for (int k = 0; k < MEM_BYTES; k++) begin
              if (cnt == CNT_W'(k)) i_mem[k*8 +: 8] <= in_data;
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESET: begin
          rst_cnt <= rst_done ? '0 : rst_cnt + RC_W'(1);
        end
        ST_RUN: begin
          // Halt takes priority over a watchdog expiring on the same cycle.
          if (cpu_halt) begin
            res_o1  <= cpu_o1;
            res_o2  <= cpu_o2;
            timeout <= 1'b0;
          end else if (wd_expired) begin
            res_o1  <= cpu_o1;
            res_o2  <= cpu_o2;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import program_loader_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   i_mem;
  logic          cpu_rst;
  logic          cpu_halt = 1'b0;
  logic [7:0]    cpu_o1;
  logic [7:0]    cpu_o2;
  logic [7:0]    res_o1;
  logic [7:0]    res_o2;
  logic          res_valid;
  logic          res_ack;
  logic          timeout;
  logic          len_err;
  logic [15:0]   cycles;
  logic          busy;
  loader_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  prog_q[$];
  int halt_at = 0;
  int run_cnt = 0;

  program_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .i_mem(i_mem), .cpu_rst(cpu_rst), .cpu_halt(cpu_halt),
    .cpu_o1(cpu_o1), .cpu_o2(cpu_o2),
    .res_o1(res_o1), .res_o2(res_o2), .res_valid(res_valid), .res_ack(res_ack),
    .timeout(timeout), .len_err(len_err), .cycles(cycles), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  // CPU stand-in: raises halt on its halt_at-th cycle out of reset (0 = never).
  always @(negedge clk) begin
    if (cpu_rst) begin
      run_cnt  = 0;
      cpu_halt = 1'b0;
    end else begin
      run_cnt  = run_cnt + 1;
      cpu_halt = (halt_at != 0) && (run_cnt >= halt_at);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack_res(input logic to, input logic [7:0] o1,
                                           input logic [7:0] o2, input logic [15:0] cyc);
    return {31'd0, to, o1, o2, cyc};
  endfunction

  // Drivers (called on a falling edge, return on a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic stream_prog(input int gap);
    while (prog_q.size() > 0) begin
      send_byte(prog_q.pop_front());
      if (prog_q.size() > 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    logic [63:0] e;
    while (!res_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    e = exp_q.pop_front();
    check({tag, "_timeout"}, 64'(timeout), 64'(e[32]));
    check({tag, "_res_o1"},  64'(res_o1),  64'(e[31:24]));
    check({tag, "_res_o2"},  64'(res_o2),  64'(e[23:16]));
    check({tag, "_cycles"},  64'(cycles),  64'(e[15:0]));
  endtask

  task automatic ack_result(input string tag);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check({tag, "_ack_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_ack_state"}, 64'(dbg_state), 64'(ST_IDLE));
    check({tag, "_ack_busy"},  64'(busy),      64'd0);
  endtask

  // Program 4,2,5,7,0 with a CPU that halts on its 3rd cycle with o1=5.
  task automatic run_first_case(input string tag, input int gap);
    cpu_o1  = 8'd5;
    cpu_o2  = 8'd0;
    halt_at = 3;
    prog_q  = '{8'd4, 8'd2, 8'd5, 8'd7, 8'd0};
    stream_prog(gap);
    check({tag, "_state_reset"}, 64'(dbg_state), 64'(ST_RESET));
    check({tag, "_cpu_rst_hold"}, 64'(cpu_rst), 64'd1);
    check({tag, "_i_mem"}, i_mem, 64'h0000_0000_0007_0502);
    @(negedge clk);
    check({tag, "_cpu_rst_fall"}, 64'(cpu_rst), 64'd0);
    check({tag, "_state_run"}, 64'(dbg_state), 64'(ST_RUN));
    exp_q.push_back(pack_res(1'b0, 8'd5, 8'd0, 16'd3));
    wait_result(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    res_ack  = 1'b0;
    cpu_o1   = 8'd0;
    cpu_o2   = 8'd0;
    #3;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_i_mem",     i_mem,          64'd0);
    check("rst_cpu_rst",   64'(cpu_rst),   64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_timeout",   64'(timeout),   64'd0);
    check("rst_len_err",   64'(len_err),   64'd0);
    check("rst_cycles",    64'(cycles),    64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Basic program, continuous stream
    run_first_case("t1", 0);
    ack_result("t1");

    // Oversized length is rejected, image untouched
    halt_at = 0;
    cpu_o1  = 8'd0;
    send_byte(8'd9);
    check("t3_len_err_pulse", 64'(len_err),   64'd1);
    check("t3_state_idle",    64'(dbg_state), 64'(ST_IDLE));
    check("t3_i_mem_kept",    i_mem,          64'h0000_0000_0007_0502);
    @(negedge clk);
    check("t3_len_err_drop",  64'(len_err),   64'd0);

    // Jump-to-self loop ends by watchdog
    prog_q = '{8'd2, 8'd1, 8'd0};
    stream_prog(0);
    check("t4_i_mem", i_mem, 64'h0000_0000_0000_0001);
    exp_q.push_back(pack_res(1'b1, 8'd0, 8'd0, 16'd255));
    wait_result("t4");
    ack_result("t4");

    // Zero-length program halts on the first RUN cycle
    halt_at = 1;
    prog_q  = '{8'd0};
    stream_prog(0);
    check("t2_state_reset", 64'(dbg_state), 64'(ST_RESET));
    check("t2_i_mem", i_mem, 64'd0);
    exp_q.push_back(pack_res(1'b0, 8'd0, 8'd0, 16'd1));
    wait_result("t2");
    ack_result("t2");

    // Gapped stream and a slow consumer
    run_first_case("t5", 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid",  64'(res_valid), 64'd1);
      check("t5_hold_o1",     64'(res_o1),    64'd5);
      check("t5_hold_cycles", 64'(cycles),    64'd3);
    end
    ack_result("t5");

    // Asynchronous reset in the middle of a load
    halt_at = 0;
    send_byte(8'd4);
    send_byte(8'd2);
    send_byte(8'd5);
    check("t6_state_load",   64'(dbg_state), 64'(ST_LOAD));
    check("t6_partial_imem", i_mem,          64'h0000_0000_0000_0502);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_i_mem",     i_mem,          64'd0);
    check("t6_cpu_rst",   64'(cpu_rst),   64'd1);
    check("t6_in_ready",  64'(in_ready),  64'd0);
    check("t6_state",     64'(dbg_state), 64'(ST_IDLE));
    check("t6_busy",      64'(busy),      64'd0);
    check("t6_cycles",    64'(cycles),    64'd0);
    check("t6_res_o1",    64'(res_o1),    64'd0);
    check("t6_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_first_case("t6_reload", 0);
    ack_result("t6_reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
